// File: rtl/wt_wbuf_pkg.sv
// Shared types for the write-through store drain buffer.
// Entry lifecycle states and a liveness helper used by the buffer and its comparator feed.
package wt_wbuf_pkg;

  typedef enum logic [1:0] {
    FREE     = 2'd0,
    PENDING  = 2'd1,
    INFLIGHT = 2'd2
  } wbuf_state_e;

  function automatic logic is_live(input wbuf_state_e s);
    return s != FREE;
  endfunction

endpackage

// File: rtl/cva6_wbuf_addr_cmp.sv
// Parallel word-address comparator across all buffer entries.
// Each entry compares only when its valid mask bit is set; results are OR-reduced.
module cva6_wbuf_addr_cmp #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 30
) (
  input  logic [DEPTH-1:0][AW-1:0] entry_addr_i,
  input  logic [DEPTH-1:0]         valid_i,
  input  logic [AW-1:0]            ld_addr_i,
  output logic                     hit_o
);

  logic [DEPTH-1:0] match;

  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = valid_i[i] && (entry_addr_i[i] == ld_addr_i);
    end
  end

  assign hit_o = |match;

endmodule

// File: rtl/cva6_wt_store_drain_buf.sv
// In-order store drain buffer feeding the write-through memory request port.
// Entries move FREE -> PENDING -> INFLIGHT -> FREE; acks must return in issue order.
module cva6_wt_store_drain_buf
  import wt_wbuf_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TID_W   = 2,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                st_valid_i,
  output logic                st_ready_o,
  input  logic [XLEN-1:0]     st_addr_i,
  input  logic [XLEN-1:0]     st_data_i,
  input  logic [XLEN/8-1:0]   st_be_i,
  output logic                mem_req_o,
  input  logic                mem_gnt_i,
  output logic [XLEN-1:0]     mem_addr_o,
  output logic [XLEN-1:0]     mem_data_o,
  output logic [XLEN/8-1:0]   mem_be_o,
  output logic [TID_W-1:0]    mem_tid_o,
  input  logic                rtrn_valid_i,
  input  logic [TID_W-1:0]    rtrn_tid_i,
  input  logic [XLEN-1:0]     ld_addr_i,
  output logic                ld_hit_o,
  output logic                empty_o,
  output logic                err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  typedef struct packed {
    logic [XLEN-1:0]   addr;
    logic [XLEN-1:0]   data;
    logic [XLEN/8-1:0] be;
    logic [TID_W-1:0]  tid;
    wbuf_state_e       state;
  } entry_t;

  entry_t           entries_q [DEPTH];
  entry_t           entries_d [DEPTH];
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [PTR_W-1:0] issue_q, issue_d;
  logic [PTR_W-1:0] head_q, head_d;
  logic [TID_W-1:0] tid_cnt_q, tid_cnt_d;
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic             err_q, err_d;

  logic [CNT_W-1:0] live_cnt;
  logic             do_push;
  logic             do_issue;
  logic             ack_ok;

  logic [DEPTH-1:0][XLEN-3:0] cmp_addr;
  logic [DEPTH-1:0]           cmp_valid;
  logic                       unused_ld_lsb;

  assign unused_ld_lsb = ^ld_addr_i[1:0];

  always_comb begin
    live_cnt  = '0;
    cmp_addr  = '0;
    cmp_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cmp_addr[i]  = entries_q[i].addr[XLEN-1:2];
      cmp_valid[i] = is_live(entries_q[i].state);
      if (cmp_valid[i]) begin
        live_cnt = live_cnt + CNT_W'(1);
      end
    end

    // Ready looks only at registered occupancy, so an ack never frees a slot for a same-cycle push.
    st_ready_o = live_cnt < DEPTH_C;
    empty_o    = live_cnt == '0;
    err_o      = err_q;

    mem_req_o  = (entries_q[issue_q].state == PENDING) && (outstanding_q < MAX_OUT_C);
    mem_addr_o = entries_q[issue_q].addr;
    mem_data_o = entries_q[issue_q].data;
    mem_be_o   = entries_q[issue_q].be;
    mem_tid_o  = tid_cnt_q;

    do_push  = st_valid_i && st_ready_o;
    do_issue = mem_req_o && mem_gnt_i;
    ack_ok   = rtrn_valid_i && (outstanding_q != '0) &&
               (entries_q[head_q].state == INFLIGHT) &&
               (entries_q[head_q].tid == rtrn_tid_i);

    entries_d     = entries_q;
    tail_d        = tail_q;
    issue_d       = issue_q;
    head_d        = head_q;
    tid_cnt_d     = tid_cnt_q;
    err_d         = err_q;
    outstanding_d = outstanding_q + CNT_W'(do_issue) - CNT_W'(ack_ok);

    // Push, issue and retire always touch distinct slots: tail is FREE, issue PENDING, head INFLIGHT.
    if (do_push) begin
      entries_d[tail_q] = '{addr: st_addr_i, data: st_data_i, be: st_be_i,
                            tid: '0, state: PENDING};
      tail_d = tail_q + PTR_W'(1);
    end

    if (do_issue) begin
      entries_d[issue_q].state = INFLIGHT;
      entries_d[issue_q].tid   = tid_cnt_q;
      tid_cnt_d = tid_cnt_q + TID_W'(1);
      issue_d   = issue_q + PTR_W'(1);
    end

    if (ack_ok) begin
      entries_d[head_q].state = FREE;
      head_d = head_q + PTR_W'(1);
    end else if (rtrn_valid_i) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= '0;
      end
      tail_q        <= '0;
      issue_q       <= '0;
      head_q        <= '0;
      tid_cnt_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        entries_q[i] <= entries_d[i];
      end
      tail_q        <= tail_d;
      issue_q       <= issue_d;
      head_q        <= head_d;
      tid_cnt_q     <= tid_cnt_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  cva6_wbuf_addr_cmp #(
    .DEPTH(DEPTH),
    .AW   (XLEN - 2)
  ) u_addr_cmp (
    .entry_addr_i(cmp_addr),
    .valid_i     (cmp_valid),
    .ld_addr_i   (ld_addr_i[XLEN-1:2]),
    .hit_o       (ld_hit_o)
  );

endmodule

// File: tb/tb_cva6_wt_store_drain_buf.sv
// Self-checking bench for the store drain buffer: directed scenarios plus a random phase,
// all compared every cycle against a queue-based model of pending and in-flight stores.
module tb_cva6_wt_store_drain_buf;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 2;
  localparam int TID_W   = 2;
  localparam int MAX_OUT = 2;
  localparam int TID_MOD = 1 << TID_W;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              st_valid_i;
  logic              st_ready_o;
  logic [XLEN-1:0]   st_addr_i;
  logic [XLEN-1:0]   st_data_i;
  logic [XLEN/8-1:0] st_be_i;
  logic              mem_req_o;
  logic              mem_gnt_i;
  logic [XLEN-1:0]   mem_addr_o;
  logic [XLEN-1:0]   mem_data_o;
  logic [XLEN/8-1:0] mem_be_o;
  logic [TID_W-1:0]  mem_tid_o;
  logic              rtrn_valid_i;
  logic [TID_W-1:0]  rtrn_tid_i;
  logic [XLEN-1:0]   ld_addr_i;
  logic              ld_hit_o;
  logic              empty_o;
  logic              err_o;

  always #5 clk = ~clk;

  cva6_wt_store_drain_buf #(
    .XLEN(XLEN), .DEPTH(DEPTH), .TID_W(TID_W), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .st_valid_i(st_valid_i), .st_ready_o(st_ready_o),
    .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_be_i(st_be_i),
    .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_be_o(mem_be_o),
    .mem_tid_o(mem_tid_o),
    .rtrn_valid_i(rtrn_valid_i), .rtrn_tid_i(rtrn_tid_i),
    .ld_addr_i(ld_addr_i), .ld_hit_o(ld_hit_o),
    .empty_o(empty_o), .err_o(err_o)
  );

  // Model: stores waiting to be granted, and granted stores awaiting their ack, both in order.
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          tid;
  } ent_t;

  ent_t pendQ[$];
  ent_t inflQ[$];
  int   nextTid = 0;
  bit   modelErr = 1'b0;
  int   errors = 0;
  int   checks = 0;

  function automatic bit expReady();
    return (pendQ.size() + inflQ.size()) < DEPTH;
  endfunction

  function automatic bit expReq();
    return (pendQ.size() > 0) && (inflQ.size() < MAX_OUT);
  endfunction

  function automatic bit expHit(input logic [31:0] a);
    foreach (pendQ[i]) if (pendQ[i].addr[31:2] == a[31:2]) return 1'b1;
    foreach (inflQ[i]) if (inflQ[i].addr[31:2] == a[31:2]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".ready"}, 64'(st_ready_o), 64'(expReady()));
    check({tag, ".req"},   64'(mem_req_o),  64'(expReq()));
    if (expReq()) begin
      check({tag, ".addr"}, 64'(mem_addr_o), 64'(pendQ[0].addr));
      check({tag, ".data"}, 64'(mem_data_o), 64'(pendQ[0].data));
      check({tag, ".be"},   64'(mem_be_o),   64'(pendQ[0].be));
      check({tag, ".tid"},  64'(mem_tid_o),  64'(nextTid));
    end
    check({tag, ".empty"}, 64'(empty_o),  64'(pendQ.size() == 0 && inflQ.size() == 0));
    check({tag, ".hit"},   64'(ld_hit_o), 64'(expHit(ld_addr_i)));
    check({tag, ".err"},   64'(err_o),    64'(modelErr));
  endtask

  task automatic applyStimulus(input bit v, input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] be, input bit gnt, input bit rv,
                               input int rtid, input logic [31:0] ld);
    st_valid_i   = v;
    st_addr_i    = a;
    st_data_i    = d;
    st_be_i      = be;
    mem_gnt_i    = gnt;
    rtrn_valid_i = rv;
    rtrn_tid_i   = TID_W'(rtid);
    ld_addr_i    = ld;
  endtask

  task automatic modelUpdate(input bit rst, input bit push, input ent_t pe,
                             input bit gnt, input bit ackV, input int ackT);
    ent_t e;
    bit   hadInfl;
    if (!rst) begin
      pendQ.delete();
      inflQ.delete();
      nextTid  = 0;
      modelErr = 1'b0;
      return;
    end
    hadInfl = inflQ.size() > 0;
    if (ackV) begin
      if (hadInfl && inflQ[0].tid == ackT) void'(inflQ.pop_front());
      else modelErr = 1'b1;
    end
    if (gnt) begin
      e = pendQ.pop_front();
      e.tid = nextTid;
      nextTid = (nextTid + 1) % TID_MOD;
      inflQ.push_back(e);
    end
    if (push) pendQ.push_back(pe);
  endtask

  // One clock: check outputs for the driven inputs, then advance DUT and model together.
  task automatic tick(input string tag);
    ent_t pe;
    bit   rst, push, gnt, ackV;
    int   ackT;
    #1;
    checkOutput(tag);
    rst     = rst_ni;
    push    = st_valid_i && expReady();
    gnt     = mem_gnt_i && expReq();
    ackV    = rtrn_valid_i;
    ackT    = int'(rtrn_tid_i);
    pe.addr = st_addr_i;
    pe.data = st_data_i;
    pe.be   = st_be_i;
    pe.tid  = 0;
    @(posedge clk);
    modelUpdate(rst, push, pe, gnt, ackV, ackT);
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 20 && (pendQ.size() > 0 || inflQ.size() > 0); i++) begin
      applyStimulus(0, 0, 0, 0, 1, inflQ.size() > 0, inflQ.size() > 0 ? inflQ[0].tid : 0, 0);
      tick(tag);
    end
    idle();
    check({tag, ".empty_after"}, 64'(empty_o), 64'd1);
  endtask

  initial begin
    rst_ni = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    tick("reset");
    check("reset.ready", 64'(st_ready_o), 64'd1);
    check("reset.req",   64'(mem_req_o),  64'd0);
    check("reset.empty", 64'(empty_o),    64'd1);
    check("reset.err",   64'(err_o),      64'd0);
    check("reset.hit",   64'(ld_hit_o),   64'd0);
    rst_ni = 1'b1;

    // Single store granted the cycle its request appears, then acked.
    applyStimulus(1, 32'h100, 32'hDEAD, 4'hF, 0, 0, 0, 0);
    tick("t1_push");
    check("t1.req",  64'(mem_req_o),  64'd1);
    check("t1.tid",  64'(mem_tid_o),  64'd0);
    check("t1.addr", 64'(mem_addr_o), 64'h100);
    check("t1.data", 64'(mem_data_o), 64'hDEAD);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    tick("t1_gnt");
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0);
    tick("t1_ack");
    check("t1.empty", 64'(empty_o), 64'd1);

    // Fill the buffer, hold a third store until a slot is retired.
    applyStimulus(1, 32'h110, 32'h1111, 4'h3, 0, 0, 0, 0);
    tick("t2_push1");
    applyStimulus(1, 32'h114, 32'h2222, 4'hC, 0, 0, 0, 0);
    tick("t2_push2");
    check("t2.full", 64'(st_ready_o), 64'd0);
    applyStimulus(1, 32'h118, 32'h3333, 4'hF, 1, 0, 0, 0);
    tick("t2_gntA");
    applyStimulus(1, 32'h118, 32'h3333, 4'hF, 1, 0, 0, 0);
    tick("t2_gntB");
    check("t2.still_full", 64'(st_ready_o), 64'd0);
    applyStimulus(1, 32'h118, 32'h3333, 4'hF, 0, 1, inflQ[0].tid, 0);
    tick("t2_ack1");
    check("t2.ready_after_ack", 64'(st_ready_o), 64'd1);
    applyStimulus(1, 32'h118, 32'h3333, 4'hF, 0, 0, 0, 0);
    tick("t2_push3");
    drain("t2_drain");

    // Request and payload must hold while the grant is withheld; tid has wrapped to 0.
    applyStimulus(1, 32'h120, 32'h5A5A, 4'h5, 0, 0, 0, 0);
    tick("t3_push");
    for (int i = 0; i < 5; i++) begin
      idle();
      tick("t3_hold");
      check("t3.hold_req",  64'(mem_req_o),  64'd1);
      check("t3.hold_addr", 64'(mem_addr_o), 64'h120);
      check("t3.hold_tid",  64'(mem_tid_o),  64'd0);
    end
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    tick("t3_gnt");
    check("t3.single_issue", 64'(mem_req_o), 64'd0);
    drain("t3_drain");

    // Two in flight with acks delayed: nothing further requested until the first ack.
    applyStimulus(1, 32'h130, 32'hA0, 4'hF, 0, 0, 0, 0);
    tick("t4_pushA");
    applyStimulus(1, 32'h134, 32'hA1, 4'hF, 1, 0, 0, 0);
    tick("t4_pushB_gntA");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    tick("t4_gntB");
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1, 32'h138, 32'hA2, 4'hF, 1, 0, 0, 0);
      tick("t4_wait");
      check("t4.no_req", 64'(mem_req_o), 64'd0);
    end
    applyStimulus(1, 32'h138, 32'hA2, 4'hF, 1, 1, inflQ[0].tid, 0);
    tick("t4_ack1");
    applyStimulus(1, 32'h138, 32'hA2, 4'hF, 0, 0, 0, 0);
    tick("t4_pushC");
    check("t4.req_third", 64'(mem_req_o), 64'd1);
    drain("t4_drain");

    // Random traffic with in-order acks.
    for (int i = 0; i < 400; i++) begin
      bit          doAck;
      logic [31:0] a, l;
      a = 32'h200 + ($urandom_range(0, 7) << 2);
      l = 32'h200 + ($urandom_range(0, 7) << 2) + $urandom_range(0, 3);
      doAck = (inflQ.size() > 0) && ($urandom_range(0, 1) == 1);
      applyStimulus($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 1) == 1, doAck, doAck ? inflQ[0].tid : 0, l);
      tick("rand");
    end
    drain("rand_drain");

    // Wrong-tid ack flags an error and leaves the head entry in flight.
    applyStimulus(1, 32'h140, 32'hBEEF, 4'hF, 0, 0, 0, 0);
    tick("t5_push");
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0);
    tick("t5_gnt");
    applyStimulus(0, 0, 0, 0, 0, 1, (inflQ[0].tid + 3) % TID_MOD, 0);
    tick("t5_badack");
    idle();
    check("t5.err",       64'(err_o),   64'd1);
    check("t5.not_empty", 64'(empty_o), 64'd0);
    tick("t5_idle");
    check("t5.err_sticky", 64'(err_o), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, inflQ[0].tid, 0);
    tick("t5_goodack");
    idle();
    check("t5.empty",     64'(empty_o), 64'd1);
    check("t5.err_still", 64'(err_o),   64'd1);

    // Load hit ignores the byte offset; reset mid-drain discards everything.
    applyStimulus(1, 32'h204, 32'h77, 4'h1, 0, 0, 0, 32'h206);
    tick("t6_push");
    check("t6.hit", 64'(ld_hit_o), 64'd1);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 32'h206);
    tick("t6_gnt");
    check("t6.hit_inflight", 64'(ld_hit_o), 64'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, inflQ[0].tid, 32'h206);
    tick("t6_ack");
    check("t6.no_hit", 64'(ld_hit_o), 64'd0);
    applyStimulus(1, 32'h300, 32'h1, 4'hF, 0, 0, 0, 32'h300);
    tick("t6_pushX");
    applyStimulus(1, 32'h304, 32'h2, 4'hF, 1, 0, 0, 32'h300);
    tick("t6_pushY");
    rst_ni = 1'b0;
    idle();
    tick("t6_reset");
    rst_ni = 1'b1;
    check("t6.empty_after_rst", 64'(empty_o),    64'd1);
    check("t6.ready_after_rst", 64'(st_ready_o), 64'd1);
    check("t6.err_after_rst",   64'(err_o),      64'd0);
    for (int i = 0; i < 3; i++) tick("t6_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
